serial_tx_port: RTL and testbench

- Register-bus output peripheral for the game board; it is the write-side counterpart of the button/vblank input registers.
- The CPU writes bytes over the existing register bus: index, read/write strobes, 16-bit write value, 16-bit registered read value.
- Bytes are queued in a small FIFO and shifted out as 8N1 UART frames on tx_o.
- Status is readable on the same bus so software can poll before writing.

---
 rtl/serial_tx_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/serial_tx_port.sv | 197 +++++++++++++++++++
 tb/tb_serial_tx_port.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial transmit port and its FIFO.
// The optional parity stage is selected in serial_tx_port by SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } tx_state_e;

   localparam logic [11:0] OFS_DATA  = 12'd0;
   localparam logic [11:0] OFS_COUNT = 12'd1;

   localparam int STAT_BUSY       = 0;
   localparam int STAT_FULL       = 1;
   localparam int STAT_OVERFLOW   = 2;
   localparam int STAT_PARITY_CAP = 3;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; rdata is the head entry.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/serial_tx_port.sv
// Register-bus UART transmitter: bytes written to DATA are queued and sent 8N1 on tx_o.
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module serial_tx_port
   import serial_tx_pkg::*;
#(
   parameter logic [11:0] BASE_INDEX = 12'd2,
   parameter int          CLK_DIV    = 217,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] register_index_i,
   input  logic        register_read_i,
   input  logic        register_write_i,
   input  logic [15:0] register_write_value_i,
   output logic [15:0] register_read_value_o,
   output logic        read_valid_o,
   output logic        tx_o,
   output tx_state_e   dbg_state
);

   localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
   localparam logic [11:0] DATA_INDEX  = BASE_INDEX + OFS_DATA;
   localparam logic [11:0] COUNT_INDEX = BASE_INDEX + OFS_COUNT;
`ifdef SERIAL_TX_PARITY_EN
   localparam logic        PARITY_CAP  = 1'b1;
   localparam tx_state_e   AFTER_DATA  = PARITY;
`else
   localparam logic        PARITY_CAP  = 1'b0;
   localparam tx_state_e   AFTER_DATA  = STOP;
`endif

   logic          wr_data_hit;
   logic          rd_data_hit;
   logic          rd_count_hit;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic [15:0]   count_ext;
   logic [15:0]   status;
   logic          overflow;
   logic          overflow_set;
   logic          unused_hi;

   tx_state_e     state;
   logic [15:0]   baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic          tx_q;
   logic          line_bit;

   assign wr_data_hit  = register_write_i && (register_index_i == DATA_INDEX);
   assign rd_data_hit  = register_read_i  && (register_index_i == DATA_INDEX);
   assign rd_count_hit = register_read_i  && (register_index_i == COUNT_INDEX);
   assign unused_hi    = ^register_write_value_i[15:8];

   // The FIFO head is consumed when idle or on the last cycle of a stop bit.
   assign fifo_pop     = !fifo_empty &&
                         ((state == IDLE) || ((state == STOP) && (baud_cnt == 16'd0)));
   assign fifo_push    = wr_data_hit;
   assign overflow_set = wr_data_hit && fifo_full && !fifo_pop;
   assign count_ext    = 16'(fifo_count);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wdata   (register_write_value_i[7:0]),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      status                  = '0;
      status[STAT_BUSY]       = (state != IDLE) || !fifo_empty;
      status[STAT_FULL]       = fifo_full;
      status[STAT_OVERFLOW]   = overflow;
      status[STAT_PARITY_CAP] = PARITY_CAP;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow              <= 1'b0;
         register_read_value_o <= '0;
         read_valid_o          <= 1'b0;
      end else begin
         read_valid_o <= rd_data_hit || rd_count_hit;
         if (rd_data_hit) begin
            register_read_value_o <= status;
         end else if (rd_count_hit) begin
            register_read_value_o <= count_ext;
         end
         // A new overflow in the same cycle as a status read survives the clear.
         overflow <= overflow_set || (overflow && !rd_data_hit);
      end
   end

   always_comb begin
      line_bit = 1'b1;
      case (state)
         IDLE:    line_bit = 1'b1;
         START:   line_bit = 1'b0;
         DATA:    line_bit = shreg[0];
         PARITY:  line_bit = par_bit;
         STOP:    line_bit = 1'b1;
         default: line_bit = 1'b1;
      endcase
   end

   // tx_o follows the current state one cycle later, so every level lasts CLK_DIV cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         tx_q <= line_bit;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  shreg    <= fifo_rdata;
                  par_bit  <= even_parity(fifo_rdata);
                  baud_cnt <= DIV_LAST;
                  state    <= START;
               end
            end
            START: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= DIV_LAST;
                  bit_cnt  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            DATA: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= DIV_LAST;
                  if (bit_cnt == 3'd7) begin
                     state <= AFTER_DATA;
                  end else begin
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            PARITY: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= DIV_LAST;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            STOP: begin
               if (baud_cnt == 16'd0) begin
                  if (!fifo_empty) begin
                     shreg    <= fifo_rdata;
                     par_bit  <= even_parity(fifo_rdata);
                     baud_cnt <= DIV_LAST;
                     state    <= START;
                  end else begin
                     baud_cnt <= '0;
                     state    <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            default: begin
               baud_cnt <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign tx_o      = tx_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_serial_tx_port.sv
// Bench for serial_tx_port: directed scenarios plus random bus traffic against a frame-level model.
// Build with SERIAL_TX_PARITY_EN defined to exercise the parity variant.
module tb_serial_tx_port;
   import serial_tx_pkg::*;

   localparam int          D    = 4;
   localparam int          DEP  = 4;
   localparam logic [11:0] BASE = 12'd2;
`ifdef SERIAL_TX_PARITY_EN
   localparam int          PAR  = 1;
`else
   localparam int          PAR  = 0;
`endif
   localparam logic        PAR_BIT = (PAR == 1);
   localparam int          FB   = 10 + PAR;
   localparam int          FL   = FB * D;

   logic        clk;
   logic        reset_n;
   logic [11:0] idx;
   logic        rd;
   logic        wr;
   logic [15:0] wval;
   logic [15:0] rd_value;
   logic        rd_valid;
   logic        tx;
   tx_state_e   dbg_state;

   int total = 0;
   int bad   = 0;

   logic [15:0] cap_val;
   logic        cap_vld;
   int          edge_cnt = 0;

   logic [7:0]  rx_data[$];
   int          rx_t0[$];

   // model state
   logic [7:0]  m_q[$];
   int          cyc = 0;
   logic        m_active = 1'b0;
   int          m_p = 0;
   logic [10:0] m_frame = '1;
   logic        m_ovf = 1'b0;
   logic        exp_tx = 1'b1;
   logic        exp_valid = 1'b0;
   logic [15:0] exp_val = '0;

   serial_tx_port #(
      .BASE_INDEX (BASE),
      .CLK_DIV    (D),
      .FIFO_DEPTH (DEP)
   ) dut (
      .clk                    (clk),
      .reset_n                (reset_n),
      .register_index_i       (idx),
      .register_read_i        (rd),
      .register_write_i       (wr),
      .register_write_value_i (wval),
      .register_read_value_o  (rd_value),
      .read_valid_o           (rd_valid),
      .tx_o                   (tx),
      .dbg_state              (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b);
      logic [10:0] f;
      f        = '1;
      f[0]     = 1'b0;
      f[8:1]   = b;
      if (PAR == 1) f[9] = ^b;
      return f;
   endfunction

   // Frame-level reference: a byte queue, a sticky overflow flag and the start
   // cycle of the frame in flight; line level follows from (cycle - start) / D.
   always @(posedge clk or negedge reset_n) begin : model
      int   cur;
      int   sz;
      logic hit_d;
      logic hit_c;
      logic done;
      logic popped;
      logic set_ovf;
      if (!reset_n) begin
         m_q.delete();
         cyc       <= 0;
         m_active  <= 1'b0;
         m_p       <= 0;
         m_ovf     <= 1'b0;
         exp_tx    <= 1'b1;
         exp_valid <= 1'b0;
         exp_val   <= '0;
      end else begin
         cur = cyc + 1;
         cyc <= cur;
         sz  = m_q.size();
         if (m_active && cur > m_p && cur <= m_p + FL) exp_tx <= m_frame[(cur - m_p - 1) / D];
         else exp_tx <= 1'b1;
         hit_d = rd && (idx == BASE);
         hit_c = rd && (idx == BASE + 12'd1);
         exp_valid <= hit_d || hit_c;
         if (hit_d) exp_val <= {12'd0, PAR_BIT, m_ovf, (sz == DEP), (m_active || sz != 0)};
         else if (hit_c) exp_val <= 16'(sz);
         done   = m_active && (cur == m_p + FL);
         popped = (!m_active || done) && (sz > 0);
         if (popped) begin
            m_frame  <= make_frame(m_q.pop_front());
            m_p      <= cur;
            m_active <= 1'b1;
         end else if (done) begin
            m_active <= 1'b0;
         end
         set_ovf = 1'b0;
         if (wr && idx == BASE) begin
            if (sz < DEP || popped) m_q.push_back(wval[7:0]);
            else set_ovf = 1'b1;
         end
         m_ovf <= set_ovf || (m_ovf && !hit_d);
      end
   end

   always @(negedge clk) begin
      check("cmp_tx", {31'd0, tx}, {31'd0, exp_tx});
      check("cmp_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
      check("cmp_value", {16'd0, rd_value}, {16'd0, exp_val});
   end

   // Passive line decoder: mid-bit sampling, records payload and start cycle.
   initial begin : rx_mon
      logic [10:0] bits;
      int          t0;
      forever begin
         @(posedge clk); #1;
         if (reset_n && tx === 1'b0) begin
            t0   = edge_cnt;
            bits = '0;
            repeat (D / 2) @(posedge clk);
            for (int k = 1; k < FB; k++) begin
               repeat (D) @(posedge clk);
               #1;
               bits[k] = tx;
            end
            rx_data.push_back(bits[8:1]);
            rx_t0.push_back(t0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_cycle(input logic r, input logic w, input logic [11:0] i, input logic [15:0] v);
      rd   = r;
      wr   = w;
      idx  = i;
      wval = v;
      @(posedge clk); #1;
      cap_val = rd_value;
      cap_vld = rd_valid;
      #1;
      rd = 1'b0;
      wr = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send_and_sample(input logic [15:0] v, output logic [10:0] seq,
                                  output logic t1, output logic t2);
      bus_cycle(1'b0, 1'b1, BASE, v);
      step(); t1 = tx;
      step(); t2 = tx;
      seq = '1;
      for (int k = 0; k < FB; k++) begin
         step();
         seq[k] = tx;
         repeat (D - 1) step();
      end
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      logic [10:0] seq;
      logic        t1;
      logic        t2;
      int          lows;
      int          dens;
      int          r;
      int          k;
      rd = 1'b0; wr = 1'b0; idx = '0; wval = '0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_vld", {31'd0, rd_valid}, 32'd0);
      check("reset_val", {16'd0, rd_value}, 32'd0);
      check("reset_state", {29'd0, dbg_state}, {29'd0, IDLE});
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;

      // idle line after reset
      lows = 0;
      repeat (100) begin
         step();
         if (tx !== 1'b1) lows++;
      end
      #1;
      check("idle_line", lows, 0);
      bus_cycle(1'b1, 1'b0, BASE, 16'h0);
      check("idle_status", {16'd0, cap_val}, {28'd0, PAR_BIT, 3'b000});
      check("idle_status_vld", {31'd0, cap_vld}, 32'd1);
      step();
      check("valid_once", {31'd0, rd_valid}, 32'd0);
      #1;

      // single byte, upper bits ignored
      send_and_sample(16'h0155, seq, t1, t2);
      check("latency_n1", {31'd0, t1}, 32'd1);
      check("latency_n2", {31'd0, t2}, 32'd0);
`ifdef SERIAL_TX_PARITY_EN
      check("frame_55", {21'd0, seq}, 32'h4AA);
`else
      check("frame_55", {22'd0, seq[9:0]}, 32'h2AA);
`endif
      idle_cycles(30);

      // burst with overflow
      rx_data.delete(); rx_t0.delete();
      for (int i = 0; i < 6; i++) bus_cycle(1'b0, 1'b1, BASE, 16'h0041 + 16'(i));
      bus_cycle(1'b1, 1'b0, BASE + 12'd1, 16'h0);
      check("burst_count", {16'd0, cap_val}, 32'd4);
      bus_cycle(1'b1, 1'b0, BASE, 16'h0);
      check("burst_status", {16'd0, cap_val}, {28'd0, PAR_BIT, 3'b111});
      bus_cycle(1'b1, 1'b0, BASE, 16'h0);
      check("burst_status2", {16'd0, cap_val}, {28'd0, PAR_BIT, 3'b011});
      idle_cycles(5 * FL + 40);
      check("burst_nbytes", rx_data.size(), 5);
      for (int i = 0; i < 5 && i < rx_data.size(); i++) begin
         check("burst_byte", {24'd0, rx_data[i]}, 32'h41 + i);
         if (i > 0) check("burst_gap", rx_t0[i] - rx_t0[i-1], FL);
      end

      // count read mid-transmission, foreign index read
      bus_cycle(1'b0, 1'b1, BASE, 16'h0010);
      bus_cycle(1'b0, 1'b1, BASE, 16'h0020);
      bus_cycle(1'b1, 1'b0, BASE + 12'd1, 16'h0);
      check("mid_count", {16'd0, cap_val}, 32'd1);
      bus_cycle(1'b1, 1'b0, 12'd9, 16'h0);
      check("foreign_hold", {16'd0, cap_val}, 32'd1);
      check("foreign_vld", {31'd0, cap_vld}, 32'd0);
      idle_cycles(2 * FL + 20);

      // reset in the middle of a data bit
      bus_cycle(1'b0, 1'b1, BASE, 16'h0000);
      bus_cycle(1'b0, 1'b1, BASE, 16'h0000);
      bus_cycle(1'b0, 1'b1, BASE, 16'h0000);
      idle_cycles(6);
      check("pre_reset_low", {31'd0, tx}, 32'd0);
      check("pre_reset_state", {29'd0, dbg_state}, {29'd0, DATA});
      reset_n = 1'b0;
      #1;
      check("async_tx", {31'd0, tx}, 32'd1);
      #1;
      idle_cycles(2);
      reset_n = 1'b1;
      bus_cycle(1'b1, 1'b0, BASE + 12'd1, 16'h0);
      check("post_reset_count", {16'd0, cap_val}, 32'd0);
      lows = 0;
      repeat (60) begin
         step();
         if (tx !== 1'b1) lows++;
      end
      #1;
      check("post_reset_line", lows, 0);

`ifdef SERIAL_TX_PARITY_EN
      send_and_sample(16'h0007, seq, t1, t2);
      check("par_frame_07", {21'd0, seq}, 32'h60E);
      idle_cycles(30);
      rx_data.delete(); rx_t0.delete();
      bus_cycle(1'b0, 1'b1, BASE, 16'h0007);
      bus_cycle(1'b0, 1'b1, BASE, 16'h0007);
      idle_cycles(2 * FL + 30);
      check("par_nframes", rx_t0.size(), 2);
      if (rx_t0.size() == 2) check("par_frame_len", rx_t0[1] - rx_t0[0], 44);
      bus_cycle(1'b1, 1'b0, BASE, 16'h0);
      check("par_cap", {16'd0, cap_val}, 32'h0008);
`endif

      // random traffic of varying density
      for (int seg = 0; seg < 10; seg++) begin
         dens = $urandom_range(10, 90);
         for (int c = 0; c < 200; c++) begin
            r = $urandom_range(0, 99);
            if (r < dens) begin
               k = $urandom_range(0, 9);
               case (k)
                  0, 1, 2, 3, 4: bus_cycle(1'b0, 1'b1, BASE, 16'($urandom));
                  5: bus_cycle(1'b0, 1'b1, BASE + 12'd1, 16'($urandom));
                  6: bus_cycle(1'b1, 1'b0, BASE, 16'h0);
                  7: bus_cycle(1'b1, 1'b0, BASE + 12'd1, 16'h0);
                  8: bus_cycle(1'b1, 1'b0, 12'($urandom_range(4, 4095)), 16'h0);
                  default: bus_cycle(1'b1, 1'b1, BASE, 16'($urandom));
               endcase
            end else begin
               bus_cycle(1'b0, 1'b0, 12'($urandom), 16'($urandom));
            end
         end
      end
      idle_cycles((DEP + 2) * FL + 50);
      bus_cycle(1'b1, 1'b0, BASE, 16'h0);
      bus_cycle(1'b1, 1'b0, BASE, 16'h0);
      check("drained_status", {16'd0, cap_val}, {28'd0, PAR_BIT, 3'b000});
      idle_cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
